pe_egress_packetizer: RTL and testbench

// - Sits between a neuron's output (finout/finoutvalid) and a switch's PE input port (i_data_pe/i_valid_pe/o_ready_pe).
// - Buffers neuron results in a small FIFO.
// - Fans each result out as NUM_DST packets, one per downstream neuron, so the bufferless switch receives one packet at a time under backpressure.
// - Packet format, MSB..LSB: {data[DATA_WIDTH], src_x[X_SIZE], src_y[Y_SIZE], dst_x[X_SIZE], dst_y[Y_SIZE]}.
//   - dst_x occupies [3:2] and dst_y occupies [1:0] for the default sizes, matching switch routing.

---
 rtl/pe_egress_packetizer.sv | 136 +++++++++++++
 tb/tb_pe_egress_packetizer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pe_egress_packetizer.sv
// pe_egress_packetizer: buffers neuron results and fans each out as NUM_DST switch packets.
// Define PKT_DROP_CNT_EN to add a saturating o_drop_cnt of results dropped while the FIFO is full.
module pe_egress_packetizer #(
    parameter int X_COORD     = 2,
    parameter int Y_COORD     = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int X_SIZE      = 2,
    parameter int Y_SIZE      = 2,
    parameter int TOTAL_WIDTH = 2*X_SIZE + 2*Y_SIZE + DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int DST_X0      = 3,
    parameter int DST_Y0      = 0,
    parameter int NUM_DST     = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_valid_n,
    input  logic [DATA_WIDTH-1:0]           i_data_n,
    output logic                            o_ready_n,
    output logic                            o_valid_sw,
    output logic [TOTAL_WIDTH-1:0]          o_data_sw,
    input  logic                            i_ready_sw,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_cnt,
    output logic                            o_busy
`ifdef PKT_DROP_CNT_EN
    ,
    output logic [7:0]                      o_drop_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = NUM_DST > 1 ? $clog2(NUM_DST) : 1;
    localparam logic [X_SIZE-1:0] SRC_X = X_SIZE'(X_COORD);
    localparam logic [Y_SIZE-1:0] SRC_Y = Y_SIZE'(Y_COORD);
    localparam logic [X_SIZE-1:0] DST_X = X_SIZE'(DST_X0);
    localparam logic [Y_SIZE-1:0] DST_Y = Y_SIZE'(DST_Y0);
    localparam logic [KW-1:0]     K_LAST = KW'(NUM_DST - 1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_nx;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           cnt;
    logic [KW-1:0]           k, k_nx;
    logic                    valid_nx;
    logic [TOTAL_WIDTH-1:0]  data_nx;
    logic                    push, pop, xfer, k_last;

    function automatic logic [TOTAL_WIDTH-1:0] pkt(input logic [DATA_WIDTH-1:0] d, input logic [KW-1:0] kk);
        return {d, SRC_X, SRC_Y, DST_X, DST_Y + Y_SIZE'(kk)};
    endfunction

    assign o_ready_n  = cnt != CNT_FULL;
    assign push       = i_valid_n & o_ready_n;
    assign xfer       = o_valid_sw & i_ready_sw;
    assign k_last     = k == K_LAST;
    assign o_fifo_cnt = cnt;
    assign o_busy     = (state == SEND) | (cnt != '0);

    always_ff @(posedge clk) begin
        state <= rstn ? state_nx : IDLE;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cnt != '0 ? SEND : IDLE;
            SEND:    state_nx = (xfer & k_last & cnt == CW'(1)) ? IDLE : SEND;
            default: state_nx = IDLE;
        endcase
    end

    // Next packet is computed here and registered below so o_data_sw/o_valid_sw stay glitch-free.
    always_comb begin
        pop      = 1'b0;
        k_nx     = k;
        valid_nx = o_valid_sw;
        data_nx  = o_data_sw;
        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    k_nx     = '0;
                    valid_nx = 1'b1;
                    data_nx  = pkt(mem[rd_ptr], '0);
                end
            end
            SEND: begin
                if (xfer && !k_last) begin
                    k_nx    = k + KW'(1);
                    data_nx = pkt(mem[rd_ptr], k + KW'(1));
                end else if (xfer) begin
                    pop      = 1'b1;
                    k_nx     = '0;
                    valid_nx = cnt > CW'(1);
                    data_nx  = cnt > CW'(1) ? pkt(mem[rd_ptr + PW'(1)], '0) : o_data_sw;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            k          <= '0;
            o_valid_sw <= 1'b0;
            o_data_sw  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
        end else begin
            k          <= k_nx;
            o_valid_sw <= valid_nx;
            o_data_sw  <= data_nx;
            wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
            cnt        <= (push & ~pop) ? cnt + CW'(1) : (pop & ~push) ? cnt - CW'(1) : cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_data_n;
    end

`ifdef PKT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            o_drop_cnt <= '0;
        else if (i_valid_n && !o_ready_n && o_drop_cnt != 8'hFF)
            o_drop_cnt <= o_drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pe_egress_packetizer.sv
// tb_pe_egress_packetizer: directed checks of fan-out, backpressure, full/drop, reset and dst_y wrap.
module tb_pe_egress_packetizer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid_n;
    logic [7:0]  i_data_n;
    logic        i_ready_sw;
    logic        o_ready_n, o_valid_sw, o_busy;
    logic [15:0] o_data_sw;
    logic [2:0]  o_fifo_cnt;
    logic        w_ready_n, w_valid_sw, w_busy;
    logic [15:0] w_data_sw;
    logic [2:0]  w_fifo_cnt;
`ifdef PKT_DROP_CNT_EN
    logic [7:0]  o_drop_cnt, w_drop_cnt;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_egress_packetizer u_dut (
        .clk(clk), .rstn(rstn), .i_valid_n(i_valid_n), .i_data_n(i_data_n),
        .o_ready_n(o_ready_n), .o_valid_sw(o_valid_sw), .o_data_sw(o_data_sw),
        .i_ready_sw(i_ready_sw), .o_fifo_cnt(o_fifo_cnt), .o_busy(o_busy)
`ifdef PKT_DROP_CNT_EN
        , .o_drop_cnt(o_drop_cnt)
`endif
    );

    pe_egress_packetizer #(.DST_Y0(3)) u_wrap (
        .clk(clk), .rstn(rstn), .i_valid_n(i_valid_n), .i_data_n(i_data_n),
        .o_ready_n(w_ready_n), .o_valid_sw(w_valid_sw), .o_data_sw(w_data_sw),
        .i_ready_sw(i_ready_sw), .o_fifo_cnt(w_fifo_cnt), .o_busy(w_busy)
`ifdef PKT_DROP_CNT_EN
        , .o_drop_cnt(w_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_valid_n = 1'b0; i_data_n = '0; i_ready_sw = 1'b1;
        step(2);
        chk("rst_valid", 32'(o_valid_sw), 32'd0);
        chk("rst_data", 32'(o_data_sw), 32'd0);
        chk("rst_cnt", 32'(o_fifo_cnt), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rstn = 1'b1;
        step();
        chk("rst_ready", 32'(o_ready_n), 32'd1);

        // single result, switch always ready
        i_valid_n = 1'b1; i_data_n = 8'hA5;
        step();
        i_valid_n = 1'b0;
        chk("lat_valid_early", 32'(o_valid_sw), 32'd0);
        chk("lat_cnt", 32'(o_fifo_cnt), 32'd1);
        chk("lat_busy", 32'(o_busy), 32'd1);
        step();
        chk("p0_valid", 32'(o_valid_sw), 32'd1);
        chk("p0_data", 32'(o_data_sw), 32'hA59C);
        chk("wrap_p0", 32'(w_data_sw), 32'hA59F);
        step();
        chk("p1_valid", 32'(o_valid_sw), 32'd1);
        chk("p1_data", 32'(o_data_sw), 32'hA59D);
        chk("wrap_p1", 32'(w_data_sw), 32'hA59C);
        step();
        chk("done_valid", 32'(o_valid_sw), 32'd0);
        chk("done_cnt", 32'(o_fifo_cnt), 32'd0);
        chk("done_busy", 32'(o_busy), 32'd0);

        // backpressure hold
        i_ready_sw = 1'b0; i_valid_n = 1'b1; i_data_n = 8'hA5;
        step();
        i_valid_n = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(o_valid_sw), 32'd1);
            chk("hold_data", 32'(o_data_sw), 32'hA59C);
            step();
        end
        i_ready_sw = 1'b1;
        chk("rel_p0", 32'(o_data_sw), 32'hA59C);
        step();
        chk("rel_p1", 32'(o_data_sw), 32'hA59D);
        step();
        chk("rel_done", 32'(o_valid_sw), 32'd0);

        // fill to full, drop the fifth, then drain back-to-back
        i_ready_sw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            i_valid_n = 1'b1; i_data_n = 8'(i);
            step();
            if (i == 3) chk("fill_ready3", 32'(o_ready_n), 32'd1);
            if (i == 4) chk("full_ready", 32'(o_ready_n), 32'd0);
            if (i == 4) chk("full_cnt", 32'(o_fifo_cnt), 32'd4);
        end
        i_valid_n = 1'b0;
        chk("drop_cnt_unchanged", 32'(o_fifo_cnt), 32'd4);
`ifdef PKT_DROP_CNT_EN
        chk("drop_counter", 32'(o_drop_cnt), 32'd1);
`endif
        i_ready_sw = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_valid", 32'(o_valid_sw), 32'd1);
            chk("drain_data", 32'(o_data_sw), {16'd0, 8'(j / 2 + 1), 8'h9C | 8'(j % 2)});
            step();
        end
        chk("drain_done", 32'(o_valid_sw), 32'd0);
        chk("drain_cnt", 32'(o_fifo_cnt), 32'd0);

        // reset while sending with three results buffered
        i_ready_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid_n = 1'b1; i_data_n = 8'h70 + 8'(i);
            step();
        end
        i_valid_n = 1'b0;
        chk("pre_rst_cnt", 32'(o_fifo_cnt), 32'd3);
        chk("pre_rst_valid", 32'(o_valid_sw), 32'd1);
        rstn = 1'b0;
        step();
        chk("mid_rst_valid", 32'(o_valid_sw), 32'd0);
        chk("mid_rst_cnt", 32'(o_fifo_cnt), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        rstn = 1'b1; i_ready_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", 32'(o_valid_sw), 32'd0);
        end

        // push coinciding with final pop at cnt=2
        i_ready_sw = 1'b0;
        i_valid_n = 1'b1; i_data_n = 8'h11;
        step();
        i_data_n = 8'h22;
        step();
        i_valid_n = 1'b0;
        chk("pp_cnt2", 32'(o_fifo_cnt), 32'd2);
        chk("pp_p0", 32'(o_data_sw), 32'h119C);
        i_ready_sw = 1'b1;
        step();
        chk("pp_p1", 32'(o_data_sw), 32'h119D);
        i_valid_n = 1'b1; i_data_n = 8'h33;
        step();
        i_valid_n = 1'b0;
        chk("pp_cnt_hold", 32'(o_fifo_cnt), 32'd2);
        chk("pp_nobubble_valid", 32'(o_valid_sw), 32'd1);
        chk("pp_next", 32'(o_data_sw), 32'h229C);
        step();
        chk("pp_next1", 32'(o_data_sw), 32'h229D);
        step();
        chk("pp_third", 32'(o_data_sw), 32'h339C);
        chk("pp_third_cnt", 32'(o_fifo_cnt), 32'd1);
        step();
        chk("pp_third1", 32'(o_data_sw), 32'h339D);
        step();
        chk("pp_done", 32'(o_valid_sw), 32'd0);
        chk("pp_done_cnt", 32'(o_fifo_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
